// File: rtl/game_link_pkg.sv
// Shared framing constants and decoded game-state types for the inter-board game link.
// Imported by both the receiver (game_link_rx) and the transmitter (game_link_tx).
package game_link_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_LEN   = 17;
    localparam int         FIELD_W     = 12;
    localparam int         SCORE_W     = 9;
    localparam int         FLG_ENDGAME = 0;
    localparam int         FLG_HIT     = 1;

    // Everything between the sync byte and the checksum byte
    localparam int PAYLOAD_LEN = FRAME_LEN - 2;
    localparam int SHADOW_W    = 8 * PAYLOAD_LEN;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_PAYLOAD,
        ST_CHECK
    } link_state_t;

    typedef struct packed {
        logic [FIELD_W-1:0] x1;
        logic [FIELD_W-1:0] y1;
        logic [FIELD_W-1:0] x2;
        logic [FIELD_W-1:0] y2;
    } rect_t;

    typedef struct packed {
        rect_t              ball;
        rect_t              pad;
        logic [SCORE_W-1:0] score;
        logic               endgame;
        logic               hit;
    } game_state_t;

endpackage

// File: rtl/game_link_rx.sv
// Frames the UART byte stream, verifies the XOR checksum and publishes the remote game state.
// Outputs update on the checksum byte's edge; always ready, no backpressure.
module game_link_rx
    import game_link_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned LINK_CYC    = 10000000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic [7:0]          i_data,
    output logic [FIELD_W-1:0]  o_ball_x1,
    output logic [FIELD_W-1:0]  o_ball_y1,
    output logic [FIELD_W-1:0]  o_ball_x2,
    output logic [FIELD_W-1:0]  o_ball_y2,
    output logic [FIELD_W-1:0]  o_pad_x1,
    output logic [FIELD_W-1:0]  o_pad_y1,
    output logic [FIELD_W-1:0]  o_pad_x2,
    output logic [FIELD_W-1:0]  o_pad_y2,
    output logic [SCORE_W-1:0]  o_score,
    output logic                o_endgame,
    output logic                o_hit,
    output logic                o_update,
    output logic                o_err,
    output logic [7:0]          o_err_cnt,
    output logic                o_link
);

    localparam int GAP_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int LINK_W = $clog2(LINK_CYC + 1);

    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(TIMEOUT_CYC);
    localparam logic [GAP_W-1:0]  GAP_HIT   = GAP_W'(TIMEOUT_CYC - 1);
    localparam logic [LINK_W-1:0] LINK_LOAD = LINK_W'(LINK_CYC);
    localparam logic [3:0]        LAST_IDX  = 4'(PAYLOAD_LEN - 1);

    // Shadow layout: eight fields at the top, then the 16-bit score word, then flags
    localparam int FIELDS_LSB = SHADOW_W - 8 * FIELD_W;
    localparam int SCORE_LSB  = 8;

    link_state_t          r_state;
    logic [3:0]           r_idx;
    logic [7:0]           r_xor;
    logic [SHADOW_W-1:0]  r_shadow;
    game_state_t          r_out;
    logic                 r_update;
    logic                 r_err;
    logic [7:0]           r_err_cnt;
    logic [GAP_W-1:0]     r_gap;
    logic [LINK_W-1:0]    r_link_cnt;
    logic                 r_link;

    logic                 w_in_frame;
    logic                 w_timeout;
    logic                 w_chk_byte;
    logic                 w_good;
    logic                 w_err;
    logic [LINK_W-1:0]    w_link_next;
    game_state_t          w_frame;
    logic [12:0]          w_unused_bits;

    assign w_in_frame = (r_state == ST_PAYLOAD) || (r_state == ST_CHECK);

    // A byte arriving on the would-be timeout edge takes priority over the abort
    assign w_timeout  = w_in_frame && !i_valid && (r_gap == GAP_HIT);
    assign w_chk_byte = (r_state == ST_CHECK) && i_valid;
    assign w_good     = w_chk_byte && (i_data == r_xor);
    assign w_err      = (w_chk_byte && (i_data != r_xor)) || w_timeout;

    assign w_frame.ball    = r_shadow[SHADOW_W-1 -: 4*FIELD_W];
    assign w_frame.pad     = r_shadow[FIELDS_LSB +: 4*FIELD_W];
    assign w_frame.score   = r_shadow[SCORE_LSB +: SCORE_W];
    assign w_frame.endgame = r_shadow[FLG_ENDGAME];
    assign w_frame.hit     = r_shadow[FLG_HIT];

    // Score high bits and spare flag bits carry no meaning on this link
    assign w_unused_bits = {r_shadow[FIELDS_LSB-1 : SCORE_LSB+SCORE_W], r_shadow[7:2]};

    assign w_link_next = w_good              ? LINK_LOAD :
                         (r_link_cnt != '0)  ? r_link_cnt - LINK_W'(1) :
                                               '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_HUNT;
            r_idx    <= '0;
            r_xor    <= '0;
            r_shadow <= '0;
            r_out    <= '0;
            r_update <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_update <= 1'b0;
            r_err    <= w_err;
            case (r_state)
                ST_HUNT: begin
                    if (i_valid && (i_data == SYNC_BYTE)) begin
                        r_idx   <= '0;
                        r_xor   <= '0;
                        r_state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_timeout) begin
                        r_state <= ST_HUNT;
                    end else if (i_valid) begin
                        r_shadow <= {r_shadow[SHADOW_W-9:0], i_data};
                        r_xor    <= r_xor ^ i_data;
                        r_idx    <= r_idx + 4'd1;
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_timeout) begin
                        r_state <= ST_HUNT;
                    end else if (i_valid) begin
                        if (w_good) begin
                            r_out    <= w_frame;
                            r_update <= 1'b1;
                        end
                        r_state <= ST_HUNT;
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gap <= '0;
        end else if (i_valid) begin
            r_gap <= '0;
        end else if (r_gap != GAP_MAX) begin
            r_gap <= r_gap + GAP_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_link_cnt <= '0;
            r_link     <= 1'b0;
        end else begin
            r_link_cnt <= w_link_next;
            r_link     <= (w_link_next != '0);
        end
    end

    assign o_ball_x1 = r_out.ball.x1;
    assign o_ball_y1 = r_out.ball.y1;
    assign o_ball_x2 = r_out.ball.x2;
    assign o_ball_y2 = r_out.ball.y2;
    assign o_pad_x1  = r_out.pad.x1;
    assign o_pad_y1  = r_out.pad.y1;
    assign o_pad_x2  = r_out.pad.x2;
    assign o_pad_y2  = r_out.pad.y2;
    assign o_score   = r_out.score;
    assign o_endgame = r_out.endgame;
    assign o_hit     = r_out.hit;
    assign o_update  = r_update;
    assign o_err     = r_err;
    assign o_err_cnt = r_err_cnt;
    assign o_link    = r_link;

endmodule

// File: tb/tb_game_link_rx.sv
// Self-checking bench for game_link_rx: directed frames plus randomized good/corrupt frames.
module tb_game_link_rx;
    import game_link_pkg::*;

    localparam int unsigned TO = 20;
    localparam int unsigned LK = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [7:0]  dat;
    logic [11:0] o_ball_x1, o_ball_y1, o_ball_x2, o_ball_y2;
    logic [11:0] o_pad_x1, o_pad_y1, o_pad_x2, o_pad_y2;
    logic [8:0]  o_score;
    logic        o_endgame, o_hit, o_update, o_err, o_link;
    logic [7:0]  o_err_cnt;

    always #5 clk = ~clk;

    game_link_rx #(.TIMEOUT_CYC(TO), .LINK_CYC(LK)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(vld), .i_data(dat),
        .o_ball_x1(o_ball_x1), .o_ball_y1(o_ball_y1), .o_ball_x2(o_ball_x2), .o_ball_y2(o_ball_y2),
        .o_pad_x1(o_pad_x1), .o_pad_y1(o_pad_y1), .o_pad_x2(o_pad_x2), .o_pad_y2(o_pad_y2),
        .o_score(o_score), .o_endgame(o_endgame), .o_hit(o_hit),
        .o_update(o_update), .o_err(o_err), .o_err_cnt(o_err_cnt), .o_link(o_link)
    );

    logic [106:0] obs;
    assign obs = {o_ball_x1, o_ball_y1, o_ball_x2, o_ball_y2,
                  o_pad_x1, o_pad_y1, o_pad_x2, o_pad_y2, o_score, o_endgame, o_hit};

    int n_tests = 0;
    int n_fail  = 0;
    int upd_seen = 0;
    int err_seen = 0;

    // Reference state: last accepted frame's decoded fields and the expected error count
    logic [106:0] exp_f = '0;
    int           exp_cnt = 0;
    logic [7:0]   frm [17];

    always @(negedge clk) begin
        if (o_update === 1'b1) upd_seen++;
        if (o_err === 1'b1) err_seen++;
    end

    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge clk);
        vld = v;
        dat = d;
    endtask

    task automatic build(input logic [119:0] pl, input logic [7:0] cs_flip);
        logic [7:0] cs;
        cs = 8'h00;
        frm[0] = 8'hA5;
        for (int i = 0; i < 15; i++) begin
            frm[i+1] = pl[119-8*i -: 8];
            cs = cs ^ frm[i+1];
        end
        frm[16] = cs ^ cs_flip;
    endtask

    task automatic send_frame();
        for (int i = 0; i < 17; i++) drive(1'b1, frm[i]);
    endtask

    // Payload and expected decode built independently from the same field values
    task automatic make(input logic [95:0] fv, input logic [15:0] sc, input logic [7:0] fl,
                        output logic [119:0] pl, output logic [106:0] ex);
        pl = {fv, sc, fl};
        ex = {fv, sc[8:0], fl[0], fl[1]};
    endtask

    task automatic rand_frame(output logic [119:0] pl, output logic [106:0] ex);
        logic [95:0] fv;
        for (int i = 0; i < 8; i++) fv[i*12 +: 12] = 12'($urandom);
        make(fv, 16'($urandom), 8'($urandom), pl, ex);
    endtask

    task automatic test_reset();
        rst = 1'b1; vld = 1'b0; dat = 8'h00;
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs !== '0) begin n_fail++; $display("FAIL reset_fields: got %h expected 0", obs); end
        n_tests++;
        if ({o_update, o_err, o_link} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got upd/err/link=%b expected 000", {o_update, o_err, o_link});
        end
        n_tests++;
        if (o_err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt: got %0d expected 0", o_err_cnt); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ball_x1();
        logic [119:0] pl; logic [106:0] ex; int u0;
        make({12'h140, 84'h0}, 16'h0000, 8'h00, pl, ex);
        build(pl, 8'h00);
        u0 = upd_seen;
        send_frame();
        drive(1'b0, 8'h00);
        n_tests++;
        if (o_update !== 1'b1) begin n_fail++; $display("FAIL ballx1_update_hi: got %b expected 1", o_update); end
        n_tests++;
        if (obs !== ex) begin n_fail++; $display("FAIL ballx1_fields: got %h expected %h", obs, ex); end
        n_tests++;
        if (o_link !== 1'b1) begin n_fail++; $display("FAIL ballx1_link: got %b expected 1", o_link); end
        n_tests++;
        if (o_ball_x1 !== 12'd320) begin n_fail++; $display("FAIL ballx1_value: got %0d expected 320", o_ball_x1); end
        drive(1'b0, 8'h00);
        n_tests++;
        if (o_update !== 1'b0) begin n_fail++; $display("FAIL ballx1_update_lo: got %b expected 0", o_update); end
        n_tests++;
        if ((upd_seen - u0) !== 1) begin n_fail++; $display("FAIL ballx1_update_pulses: got %0d expected 1", upd_seen - u0); end
        exp_f = ex;
    endtask

    task automatic test_score_endgame(input logic [7:0] cs_flip);
        logic [119:0] pl; logic [106:0] ex; int u0, e0;
        make(96'h0, 16'h0005, 8'h01, pl, ex);
        build(pl, cs_flip);
        u0 = upd_seen; e0 = err_seen;
        send_frame();
        drive(1'b0, 8'h00);
        if (cs_flip == 8'h00) begin
            exp_f = ex;
        end else begin
            exp_cnt++;
            n_tests++;
            if (o_err !== 1'b1) begin n_fail++; $display("FAIL badcs_err_hi: got %b expected 1", o_err); end
        end
        n_tests++;
        if (obs !== exp_f) begin n_fail++; $display("FAIL score_fields(flip=%h): got %h expected %h", cs_flip, obs, exp_f); end
        drive(1'b0, 8'h00);
        n_tests++;
        if (o_err !== 1'b0) begin n_fail++; $display("FAIL score_err_lo: got %b expected 0", o_err); end
        n_tests++;
        if ((err_seen - e0) !== int'(cs_flip != 0)) begin
            n_fail++; $display("FAIL score_err_pulses: got %0d expected %0d", err_seen - e0, int'(cs_flip != 0));
        end
        n_tests++;
        if ((upd_seen - u0) !== int'(cs_flip == 0)) begin
            n_fail++; $display("FAIL score_upd_pulses: got %0d expected %0d", upd_seen - u0, int'(cs_flip == 0));
        end
        n_tests++;
        if (o_err_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL score_errcnt: got %0d expected %0d", o_err_cnt, exp_cnt); end
    endtask

    task automatic test_timeout();
        logic [119:0] pl; logic [106:0] ex; int e0; int first;
        rand_frame(pl, ex);
        build(pl, 8'h00);
        e0 = err_seen; first = 0;
        for (int i = 0; i < 8; i++) drive(1'b1, frm[i]);
        drive(1'b0, 8'h00);
        for (int j = 1; j <= int'(TO) + 3; j++) begin
            @(negedge clk);
            if (o_err === 1'b1 && first == 0) first = j;
        end
        exp_cnt++;
        n_tests++;
        if (first !== int'(TO)) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", first, TO); end
        n_tests++;
        if ((err_seen - e0) !== 1) begin n_fail++; $display("FAIL timeout_pulses: got %0d expected 1", err_seen - e0); end
        n_tests++;
        if (o_err_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL timeout_errcnt: got %0d expected %0d", o_err_cnt, exp_cnt); end
        n_tests++;
        if (obs !== exp_f) begin n_fail++; $display("FAIL timeout_hold: got %h expected %h", obs, exp_f); end
        rand_frame(pl, ex);
        build(pl, 8'h00);
        send_frame();
        drive(1'b0, 8'h00);
        exp_f = ex;
        n_tests++;
        if (obs !== ex) begin n_fail++; $display("FAIL timeout_recover: got %h expected %h", obs, ex); end
    endtask

    task automatic test_byte_wins();
        logic [119:0] pl; logic [106:0] ex; int e0;
        rand_frame(pl, ex);
        build(pl, 8'h00);
        e0 = err_seen;
        for (int i = 0; i < 6; i++) drive(1'b1, frm[i]);
        repeat (TO - 1) drive(1'b0, 8'h00);
        for (int i = 6; i < 17; i++) drive(1'b1, frm[i]);
        drive(1'b0, 8'h00);
        exp_f = ex;
        n_tests++;
        if (o_update !== 1'b1 || obs !== ex) begin
            n_fail++; $display("FAIL byte_wins_decode: got upd=%b %h expected upd=1 %h", o_update, obs, ex);
        end
        drive(1'b0, 8'h00);
        n_tests++;
        if ((err_seen - e0) !== 0) begin n_fail++; $display("FAIL byte_wins_err: got %0d expected 0", err_seen - e0); end
    endtask

    task automatic test_garbage_a5();
        logic [119:0] pl; logic [106:0] ex;
        make({12'hA5A, 12'h5A5, 12'hA5A, 60'h0}, 16'h00A5, 8'hA5, pl, ex);
        build(pl, 8'h00);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'hFF);
        send_frame();
        drive(1'b0, 8'h00);
        exp_f = ex;
        n_tests++;
        if (obs !== ex) begin n_fail++; $display("FAIL garbage_a5_fields: got %h expected %h", obs, ex); end
        n_tests++;
        if ({o_score, o_endgame, o_hit} !== {9'h0A5, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL garbage_a5_score: got %h/%b/%b expected a5/1/0", o_score, o_endgame, o_hit);
        end
        drive(1'b0, 8'h00);
    endtask

    task automatic test_random();
        logic [119:0] pl; logic [106:0] ex; logic [7:0] flip; int u0, e0; bit bad;
        for (int k = 0; k < 24; k++) begin
            rand_frame(pl, ex);
            bad  = ($urandom_range(0, 3) == 0);
            flip = bad ? 8'($urandom_range(1, 255)) : 8'h00;
            build(pl, flip);
            u0 = upd_seen; e0 = err_seen;
            repeat ($urandom_range(0, 3)) drive(1'b0, 8'h00);
            send_frame();
            drive(1'b0, 8'h00);
            drive(1'b0, 8'h00);
            if (bad) begin
                if (exp_cnt < 255) exp_cnt++;
            end else begin
                exp_f = ex;
            end
            n_tests++;
            if (obs !== exp_f) begin n_fail++; $display("FAIL random[%0d]_fields: got %h expected %h", k, obs, exp_f); end
            n_tests++;
            if ((upd_seen - u0) !== int'(!bad)) begin
                n_fail++; $display("FAIL random[%0d]_upd: got %0d expected %0d", k, upd_seen - u0, int'(!bad));
            end
            n_tests++;
            if ((err_seen - e0) !== int'(bad)) begin
                n_fail++; $display("FAIL random[%0d]_err: got %0d expected %0d", k, err_seen - e0, int'(bad));
            end
            n_tests++;
            if (o_err_cnt !== 8'(exp_cnt)) begin
                n_fail++; $display("FAIL random[%0d]_errcnt: got %0d expected %0d", k, o_err_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [119:0] pl1, pl2; logic [106:0] ex1, ex2; int u0;
        rand_frame(pl1, ex1);
        rand_frame(pl2, ex2);
        u0 = upd_seen;
        build(pl1, 8'h00);
        send_frame();
        build(pl2, 8'h00);
        drive(1'b1, frm[0]);
        n_tests++;
        if (o_update !== 1'b1 || obs !== ex1) begin
            n_fail++; $display("FAIL b2b_first: got upd=%b %h expected upd=1 %h", o_update, obs, ex1);
        end
        for (int i = 1; i < 17; i++) drive(1'b1, frm[i]);
        drive(1'b0, 8'h00);
        exp_f = ex2;
        n_tests++;
        if (obs !== ex2) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", obs, ex2); end
        drive(1'b0, 8'h00);
        n_tests++;
        if ((upd_seen - u0) !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", upd_seen - u0); end
    endtask

    task automatic test_reset_midframe();
        logic [119:0] pl; logic [106:0] ex; int first;
        rand_frame(pl, ex);
        build(pl, 8'h00);
        for (int i = 0; i < 9; i++) drive(1'b1, frm[i]);
        @(negedge clk);
        rst = 1'b1; vld = 1'b0;
        @(negedge clk);
        exp_f = '0; exp_cnt = 0;
        n_tests++;
        if (obs !== '0) begin n_fail++; $display("FAIL midrst_fields: got %h expected 0", obs); end
        n_tests++;
        if ({o_link, o_update, o_err_cnt} !== 10'd0) begin
            n_fail++; $display("FAIL midrst_link_cnt: got link=%b upd=%b cnt=%0d expected 0", o_link, o_update, o_err_cnt);
        end
        rst = 1'b0;
        drive(1'b0, 8'h00);
        rand_frame(pl, ex);
        build(pl, 8'h00);
        send_frame();
        drive(1'b0, 8'h00);
        exp_f = ex;
        n_tests++;
        if (obs !== ex || o_link !== 1'b1) begin
            n_fail++; $display("FAIL midrst_recover: got link=%b %h expected link=1 %h", o_link, obs, ex);
        end
        first = 0;
        for (int j = 1; j <= int'(LK) + 5; j++) begin
            @(negedge clk);
            if (o_link === 1'b0 && first == 0) first = j;
        end
        n_tests++;
        if (first !== int'(LK)) begin n_fail++; $display("FAIL link_drop_cycle: got %0d expected %0d", first, LK); end
        n_tests++;
        if (obs !== exp_f) begin n_fail++; $display("FAIL link_drop_hold: got %h expected %h", obs, exp_f); end
    endtask

    initial begin
        test_reset();
        test_ball_x1();
        test_score_endgame(8'h00);
        test_score_endgame(8'h01);
        test_timeout();
        test_byte_wins();
        test_garbage_a5();
        test_random();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
